bias_buf_ctrl: RTL and testbench
================================

// Module: bias_buf_ctrl
// PURPOSE
//  Initiator-side controller for the single-port bias SRAM (spram_wrapper_bias).
//  Loads a bias stream from the DMA path into the SRAM, then replays a contiguous
//  window of it to the conv/PE array over a valid/ready stream. Sole owner of the
//  SRAM cs/we/addr/wdata pins; absorbs fixed read latency with an internal skid FIFO.
// PARAMETERS
//  DW      16  bias word width (matches SRAM DW)
//  AW      4   SRAM address width
//  DEPTH   16  SRAM depth in words (<= 2**AW)
//  RD_LAT  1   SRAM read latency in cycles (1..3), fixed
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst        in   1       synchronous reset, active-high
//  ld_start   in   1       pulse: begin load of ld_len words at addr 0
//  ld_len     in   AW+1    words to load, 0..DEPTH
//  ld_valid   in   1       load stream data valid
//  ld_data    in   DW      load stream data
//  ld_ready   out  1       load stream ready
//  rd_start   in   1       pulse: begin replay
//  rd_base    in   AW      first SRAM address to replay
//  rd_len     in   AW+1    words to replay, 0..DEPTH
//  out_valid  out  1       replay stream valid
//  out_data   out  DW      replay stream data
//  out_ready  in   1       replay stream ready
//  busy       out  1       FSM not IDLE
//  ld_done    out  1       1-cycle pulse, load complete
//  rd_done    out  1       1-cycle pulse, last replay word accepted
//  ram_cs     out  1       SRAM chip-select
//  ram_we     out  1       SRAM write enable
//  ram_addr   out  AW      SRAM address
//  ram_wdata  out  DW      SRAM write data
//  ram_rdata  in   DW      SRAM read data, valid RD_LAT cycles after read cycle
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0 (ld_ready, out_valid, busy, done pulses, ram_*);
//   counters, in-flight tags and FIFO cleared. Reset mid-op aborts, no done pulse.
//  FSM: IDLE -> LOAD (ld_start) | READ (rd_start); LOAD -> IDLE on last write;
//   READ -> IDLE on last out handshake. Starts while busy ignored. Both starts in
//   same IDLE cycle: LOAD taken, rd_start dropped.
//  LOAD: ld_ready=1 while in LOAD and written<ld_len. Each ld_valid&ld_ready cycle
//   drives ram_cs=1, ram_we=1, ram_addr=written, ram_wdata=ld_data same cycle
//   (combinational). ld_done pulses the cycle after the final write; busy drops then.
//  ld_len=0: LOAD lasts 1 cycle, ld_ready stays 0, ld_done next cycle. ld_len>DEPTH
//   clamped to DEPTH.
//  READ: issue read (ram_cs=1, ram_we=0, ram_addr=ptr) when issued<rd_len and
//   inflight+fifo_count < RD_LAT+1. ptr starts at rd_base, +1 per issue, wraps
//   DEPTH-1 -> 0 (not 2**AW). Capture ram_rdata into FIFO exactly RD_LAT cycles after
//   each issue (shift-register valid tag). FIFO depth RD_LAT+1, never overflows.
//  Output: out_valid = FIFO non-empty; out_data = FIFO head; pop on out_valid&out_ready.
//   out_data held stable while out_valid&!out_ready. Full throughput (1 word/cycle)
//   with out_ready=1; first out_valid RD_LAT+1 cycles after rd_start.
//  rd_done pulses the cycle after last pop; rd_len=0 -> rd_done 1 cycle after start.
//  ram_cs=0 whenever no write/read issued this cycle; ram_wdata=0 outside writes.
// TESTING
//  T1 rst, ld_start len=16, data 0x1000+i, ld_valid=1 -> 16 writes addr 0..15, ld_done @ cycle 17, busy 0.
//  T2 after T1, rd_start base=0 len=16, out_ready=1 -> out_data 0x1000..0x100F back-to-back, rd_done once.
//  T3 rd_start base=14 len=4 -> ram_addr 14,15,0,1; out_data 0x100E,0x100F,0x1000,0x1001.
//  T4 replay with out_ready random 50% -> no loss/dup, data stable while stalled, <=RD_LAT+1 reads outstanding.
//  T5 ld_start+rd_start same cycle, then rd_start during LOAD -> only load runs; len=0 cases pulse done next cycle.
//  T6 rst asserted mid-READ (after 5 words) -> next cycle all outputs 0, IDLE, no rd_done; fresh replay correct.

Source files
------------

// File: rtl/bias_buf_ctrl.sv
// bias_buf_ctrl: initiator-side controller for the single-port bias SRAM.
// Loads a bias stream into the SRAM starting at address 0. Then replays a
// contiguous, wrapping window of it over a valid/ready stream. A small skid
// FIFO absorbs the fixed SRAM read latency.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for ld_start / rd_start (load wins if both)
// LOAD  | accepting ld_len words, one SRAM write per handshake
// READ  | issuing reads under FIFO credit, draining FIFO to output
//
// The first read is issued in the same cycle rd_start is seen. This makes
// out_valid appear RD_LAT+1 cycles after the start pulse. The read credit
// counts the FIFO pop of the current cycle. Without that, the controller
// could not issue one word per cycle while the consumer is always ready.
module bias_buf_ctrl #(
    parameter int DW     = 16,
    parameter int AW     = 4,
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_start,
    input  logic [AW:0]   ld_len,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    input  logic          rd_start,
    input  logic [AW-1:0] rd_base,
    input  logic [AW:0]   rd_len,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          ld_done,
    output logic          rd_done,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam int FD  = RD_LAT + 1;
    localparam int FPW = $clog2(FD);
    localparam int FCW = $clog2(FD + 1);
    localparam logic [AW:0]    DEPTH_L   = (AW+1)'(DEPTH);
    localparam logic [AW:0]    ONE_L     = (AW+1)'(1);
    localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [FCW:0]   FD_L      = (FCW+1)'(FD);
    localparam logic [FPW-1:0] LAST_SLOT = FPW'(FD - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_READ = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [AW:0]     len_q, written, issued, popped;
    logic [AW:0]     ld_len_c, rd_len_c;
    logic [AW-1:0]   ptr, issue_addr, next_addr;
    logic [RD_LAT-1:0] tag;
    logic [FCW-1:0]  inflight, fifo_cnt;
    logic [FCW:0]    occ;
    logic [DW-1:0]   fifo_mem [FD];
    logic [FPW-1:0]  wr_ptr, rd_ptr;
    logic            wr_fire, rd_issue, push, pop, ld_fin, rd_fin;

    // Lengths above the SRAM depth are clamped to the depth.
    assign ld_len_c  = (ld_len > DEPTH_L) ? DEPTH_L : ld_len;
    assign rd_len_c  = (rd_len > DEPTH_L) ? DEPTH_L : rd_len;

    assign push      = tag[RD_LAT-1];
    assign out_valid = (fifo_cnt != '0);
    assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
    assign pop       = out_valid & out_ready;
    assign busy      = (state != ST_IDLE);
    assign occ       = {1'b0, inflight} + {1'b0, fifo_cnt} - (FCW+1)'(pop);
    assign next_addr = (issue_addr == LAST_ADDR) ? '0 : issue_addr + 1'b1;

    // Next-state logic and combinational SRAM/stream strobes.
    always_comb begin
        state_n    = state;
        ld_ready   = 1'b0;
        wr_fire    = 1'b0;
        rd_issue   = 1'b0;
        issue_addr = ptr;
        ram_cs     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        ld_fin     = 1'b0;
        rd_fin     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ld_start) begin
                    state_n = ST_LOAD;
                end else if (rd_start) begin
                    if (rd_len_c == '0) begin
                        rd_fin = 1'b1;
                    end else begin
                        state_n    = ST_READ;
                        rd_issue   = 1'b1;
                        issue_addr = rd_base;
                    end
                end
            end
            ST_LOAD: begin
                ld_ready = (written < len_q);
                wr_fire  = ld_valid & ld_ready;
                if (wr_fire) begin
                    ram_cs    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = written[AW-1:0];
                    ram_wdata = ld_data;
                end
                if ((len_q == '0) || (wr_fire && (written + ONE_L == len_q))) begin
                    state_n = ST_IDLE;
                    ld_fin  = 1'b1;
                end
            end
            ST_READ: begin
                if ((issued < len_q) && (occ < FD_L)) begin
                    rd_issue = 1'b1;
                end
                if (pop && (popped + ONE_L == len_q)) begin
                    state_n = ST_IDLE;
                    rd_fin  = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (rd_issue) begin
            ram_cs   = 1'b1;
            ram_addr = issue_addr;
        end
    end

    // State register, counters, done pulses and read-return tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            written  <= '0;
            issued   <= '0;
            popped   <= '0;
            ptr      <= '0;
            tag      <= '0;
            inflight <= '0;
            ld_done  <= 1'b0;
            rd_done  <= 1'b0;
        end else begin
            state   <= state_n;
            ld_done <= ld_fin;
            rd_done <= rd_fin;
            if (state == ST_IDLE) begin
                written <= '0;
                popped  <= '0;
                issued  <= (AW+1)'(rd_issue);
                if (ld_start) begin
                    len_q <= ld_len_c;
                end else if (rd_start) begin
                    len_q <= rd_len_c;
                end
            end else begin
                if (wr_fire)  written <= written + ONE_L;
                if (rd_issue) issued  <= issued + ONE_L;
                if (pop)      popped  <= popped + ONE_L;
            end
            if (rd_issue) ptr <= next_addr;
            tag[0] <= rd_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                tag[i] <= tag[i-1];
            end
            inflight <= inflight + FCW'(rd_issue) - FCW'(push);
        end
    end

    // Skid FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + FCW'(push) - FCW'(pop);
        end
    end

    // Skid FIFO storage, written when a read return lands.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= ram_rdata;
    end

endmodule

// File: tb/tb_bias_buf_ctrl.sv
// Testbench for bias_buf_ctrl with a behavioural 1-cycle-latency SRAM and a
// reference image of the loaded contents.
module tb_bias_buf_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_start, ld_valid, ld_ready;
   logic [4:0]  ld_len;
   logic [15:0] ld_data;
   logic        rd_start;
   logic [3:0]  rd_base;
   logic [4:0]  rd_len;
   logic        out_valid, out_ready;
   logic [15:0] out_data;
   logic        busy, ld_done, rd_done;
   logic        ram_cs, ram_we;
   logic [3:0]  ram_addr;
   logic [15:0] ram_wdata, ram_rdata;

   int n_tests = 0;
   int n_fail  = 0;
   logic [15:0] model [16];
   logic [15:0] sram  [16];

   bias_buf_ctrl #(.DW(16), .AW(4), .DEPTH(16), .RD_LAT(1)) dut (
      .clk(clk), .rst(rst),
      .ld_start(ld_start), .ld_len(ld_len), .ld_valid(ld_valid),
      .ld_data(ld_data), .ld_ready(ld_ready),
      .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .busy(busy), .ld_done(ld_done), .rd_done(rd_done),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   // Single-port SRAM, read data valid one cycle after the read cycle.
   always @(posedge clk) begin
      if (ram_cs && ram_we) sram[ram_addr] <= ram_wdata;
      if (ram_cs && !ram_we) ram_rdata <= sram[ram_addr];
      else ram_rdata <= 16'hDEAD;
   end

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({ld_ready, out_valid, busy, ld_done, rd_done, ram_cs, ram_we,
           ram_addr, ram_wdata, out_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got rdy=%b ov=%b busy=%b ldd=%b rdd=%b cs=%b we=%b addr=%h wd=%h od=%h req all 0",
                  ld_ready, out_valid, busy, ld_done, rd_done, ram_cs, ram_we, ram_addr, ram_wdata, out_data);
      end
      @(posedge clk); #1;
   endtask

   task automatic run_load(input int len, input bit rand_data, input bit rand_valid, input bit rd_too);
      int lc = (len > 16) ? 16 : len;
      int k = 0;
      int last_wr = 1;
      bit done = 0;
      logic [15:0] d;
      ld_start = 1'b1; ld_len = 5'(len);
      rd_start = rd_too; rd_base = 4'd0; rd_len = 5'd4;
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL load_idle_before got busy=%b req 0", busy);
      end
      @(posedge clk); #1;
      ld_start = 1'b0; rd_start = 1'b0;
      for (int cyc = 1; cyc < 200 && !done; cyc++) begin
         d = rand_data ? 16'($urandom) : 16'(32'h1000 + k);
         ld_data  = d;
         ld_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
         rd_start = rd_too && (cyc == 2);
         @(negedge clk);
         n_tests++;
         if (out_valid !== 1'b0 || rd_done !== 1'b0 || (ram_cs === 1'b1 && ram_we !== 1'b1)) begin
            n_fail++;
            $display("FAIL load_no_read cyc=%0d got ov=%b rdd=%b cs=%b we=%b req no read activity",
                     cyc, out_valid, rd_done, ram_cs, ram_we);
         end
         if (ld_done === 1'b1) begin
            done = 1;
            n_tests++;
            if (cyc != last_wr + 1) begin
               n_fail++;
               $display("FAIL ld_done_time got cyc %0d req %0d", cyc, last_wr + 1);
            end
            n_tests++;
            if (k != lc) begin
               n_fail++;
               $display("FAIL load_count got %0d writes req %0d", k, lc);
            end
            n_tests++;
            if (busy !== 1'b0) begin
               n_fail++;
               $display("FAIL load_busy_drop got busy=%b req 0", busy);
            end
         end else begin
            n_tests++;
            if (busy !== 1'b1 || ld_ready !== (k < lc)) begin
               n_fail++;
               $display("FAIL load_ready cyc=%0d got busy=%b rdy=%b req busy=1 rdy=%b", cyc, busy, ld_ready, (k < lc));
            end
            if (ld_ready === 1'b1 && ld_valid) begin
               n_tests++;
               if (ram_cs !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 4'(k) || ram_wdata !== d) begin
                  n_fail++;
                  $display("FAIL load_write cyc=%0d got cs=%b we=%b addr=%0d wd=%h req cs=1 we=1 addr=%0d wd=%h",
                           cyc, ram_cs, ram_we, ram_addr, ram_wdata, k, d);
               end
               model[k] = d;
               k++;
               last_wr = cyc;
            end else begin
               n_tests++;
               if (ram_cs !== 1'b0 || ram_wdata !== 16'h0) begin
                  n_fail++;
                  $display("FAIL load_idle_pins cyc=%0d got cs=%b wd=%h req cs=0 wd=0", cyc, ram_cs, ram_wdata);
               end
            end
         end
         @(posedge clk); #1;
      end
      ld_valid = 1'b0; rd_start = 1'b0;
      n_tests++;
      if (!done) begin
         n_fail++;
         $display("FAIL load_timeout got no ld_done req ld_done within 200 cycles");
      end
      @(negedge clk);
      n_tests++;
      if (ld_done !== 1'b0 || busy !== 1'b0 || ram_cs !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL load_after got ldd=%b busy=%b cs=%b ov=%b req all 0", ld_done, busy, ram_cs, out_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic run_read(input int base, input int len, input int ready_pct, input int abort_after);
      int lc = (len > 16) ? 16 : len;
      logic [15:0] exp_q[$];
      logic [15:0] prev_data = '0;
      logic [15:0] e;
      int nis = 0, npop = 0, first_v = -1, last_pop = 0, outst = 0;
      bit done = 0, aborted = 0, prev_stall = 0;
      for (int i = 0; i < lc; i++) exp_q.push_back(model[(base + i) % 16]);
      rd_base = 4'(base); rd_len = 5'(len);
      for (int cyc = 0; cyc < 300 && !done; cyc++) begin
         rd_start  = (cyc == 0);
         out_ready = ($urandom_range(0, 99) < ready_pct);
         @(negedge clk);
         if (ram_cs === 1'b1) begin
            n_tests++;
            if (ram_we !== 1'b0 || ram_addr !== 4'((base + nis) % 16) || nis >= lc) begin
               n_fail++;
               $display("FAIL read_issue cyc=%0d got we=%b addr=%0d n=%0d req we=0 addr=%0d n<%0d",
                        cyc, ram_we, ram_addr, nis, (base + nis) % 16, lc);
            end
            nis++; outst++;
         end
         if (out_valid === 1'b1) begin
            if (first_v < 0) begin
               first_v = cyc;
               n_tests++;
               if (cyc != 2) begin
                  n_fail++;
                  $display("FAIL first_valid got cyc %0d req 2", cyc);
               end
            end
            if (prev_stall) begin
               n_tests++;
               if (out_data !== prev_data) begin
                  n_fail++;
                  $display("FAIL stall_stable got %h req %h", out_data, prev_data);
               end
            end
            if (out_ready) begin
               n_tests++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL out_extra got %h req no more words", out_data);
               end else begin
                  e = exp_q.pop_front();
                  if (out_data !== e) begin
                     n_fail++;
                     $display("FAIL out_data word=%0d got %h req %h", npop, out_data, e);
                  end
               end
               npop++; outst--; last_pop = cyc;
            end
         end
         prev_stall = (out_valid === 1'b1) && !out_ready;
         prev_data  = out_data;
         n_tests++;
         if (outst > 2) begin
            n_fail++;
            $display("FAIL outstanding got %0d req <= 2", outst);
         end
         if (rd_done === 1'b1) begin
            done = 1;
            n_tests++;
            if (exp_q.size() != 0 || cyc != ((lc == 0) ? 1 : last_pop + 1)) begin
               n_fail++;
               $display("FAIL rd_done_time got cyc %0d left %0d req cyc %0d left 0",
                        cyc, exp_q.size(), (lc == 0) ? 1 : last_pop + 1);
            end
         end
         @(posedge clk); #1;
         if (!done && abort_after > 0 && npop == abort_after) begin
            aborted = 1; done = 1;
         end
      end
      rd_start = 1'b0;
      if (aborted) begin
         rst = 1'b1; out_ready = 1'b0;
         @(posedge clk); #1 rst = 1'b0;
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_tests++;
            if ({ld_ready, out_valid, busy, ld_done, rd_done, ram_cs, ram_we,
                 ram_addr, ram_wdata, out_data} !== '0) begin
               n_fail++;
               $display("FAIL abort_outputs c=%0d got ov=%b busy=%b rdd=%b cs=%b addr=%h od=%h req all 0",
                        c, out_valid, busy, rd_done, ram_cs, ram_addr, out_data);
            end
            @(posedge clk); #1;
         end
      end else begin
         n_tests++;
         if (!done) begin
            n_fail++;
            $display("FAIL read_timeout got no rd_done req rd_done within 300 cycles");
         end
         @(negedge clk);
         n_tests++;
         if (rd_done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_after got rdd=%b busy=%b ov=%b req all 0", rd_done, busy, out_valid);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
   endtask

   task automatic test_load_full();      run_load(16, 0, 0, 0); endtask
   task automatic test_read_full();      run_read(0, 16, 100, 0); endtask
   task automatic test_read_wrap();      run_read(14, 4, 100, 0); endtask

   task automatic test_random_replay();
      run_load(16, 1, 1, 0);
      for (int it = 0; it < 8; it++)
         run_read($urandom_range(0, 15), $urandom_range(1, 16), 50, 0);
   endtask

   task automatic test_start_priority();
      run_load(3, 1, 0, 1);
      run_load(0, 0, 0, 0);
      run_read(5, 0, 100, 0);
      run_load(20, 1, 1, 0);
      run_read(0, 16, 70, 0);
   endtask

   task automatic test_abort();
      run_read(0, 16, 100, 5);
      run_read(3, 10, 60, 0);
   endtask

   initial begin
      rst = 1'b1; ld_start = 1'b0; ld_len = '0; ld_valid = 1'b0; ld_data = '0;
      rd_start = 1'b0; rd_base = '0; rd_len = '0; out_ready = 1'b0;
      test_reset();
      test_load_full();
      test_read_full();
      test_read_wrap();
      test_random_replay();
      test_start_priority();
      test_abort();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
